cam_array: RTL

//  ROWS-row associative CAM for the associative processor. Each row holds 2**RAM_ADDR_BITS words of RAM_WIDTH bits.

---
 rtl/ap_cam_pkg.sv | 26 ++
 rtl/cam_row.sv | 55 +++++
 rtl/cam_array.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ap_cam_pkg.sv
// ap_cam_pkg: shared definitions for the associative-processor CAM array.
//   - cam_op_e    : command opcodes carried on cmd_op
//   - cam_state_e : command FSM state encoding (also exported on state_dbg)
//   - merge_bit   : one bit of the masked merge (mask=1 takes new data, mask=0 keeps old)
// The masked merge is expressed per bit so it stays independent of the word width.
package ap_cam_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR   = 2'b00,
    OP_LOAD    = 2'b01,
    OP_COMPARE = 2'b10,
    OP_WRITE   = 2'b11
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } cam_state_e;

  // new_b where mask_b=1, old_b where mask_b=0
  function automatic logic merge_bit(input logic old_b, input logic new_b, input logic mask_b);
    return mask_b ? new_b : old_b;
  endfunction

endpackage

// File: rtl/cam_row.sv
// cam_row: one CAM row of 2**RAM_ADDR_BITS words, RAM_WIDTH bits each.
// Ports:
//   clk_i         clock
//   we_i          write enable for word wr_addr_i (masked merge)
//   wr_addr_i     word written
//   wr_data_i     write data
//   wr_mask_i     write mask, 1 = bit is replaced
//   cmp_addr_i    word compared against the key
//   key_i         compare key
//   cmp_mask_i    compare mask, 1 = bit participates
//   match_o       (key & mask) == (word & mask), combinational
//   rd_addr_i     asynchronous read address
//   rd_data_o     asynchronous read data
// Storage has no reset; it maps onto distributed RAM.
module cam_row
  import ap_cam_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 1
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr_i,
  input  logic [RAM_WIDTH-1:0]     wr_data_i,
  input  logic [RAM_WIDTH-1:0]     wr_mask_i,
  input  logic [RAM_ADDR_BITS-1:0] cmp_addr_i,
  input  logic [RAM_WIDTH-1:0]     key_i,
  input  logic [RAM_WIDTH-1:0]     cmp_mask_i,
  output logic                     match_o,
  input  logic [RAM_ADDR_BITS-1:0] rd_addr_i,
  output logic [RAM_WIDTH-1:0]     rd_data_o
);

  localparam int WORDS = 2 ** RAM_ADDR_BITS;

  logic [RAM_WIDTH-1:0] mem_q [WORDS];
  logic [RAM_WIDTH-1:0] merged_d;

  always_comb begin
    merged_d = '0;
    for (int i = 0; i < RAM_WIDTH; i++) begin
      merged_d[i] = merge_bit(mem_q[wr_addr_i][i], wr_data_i[i], wr_mask_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= merged_d;
    end
  end

  assign match_o   = ((key_i & cmp_mask_i) == (mem_q[cmp_addr_i] & cmp_mask_i));
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cam_array.sv
// cam_array: ROWS-row associative CAM for the associative processor.
// Commands arrive on a valid/ready handshake and run IDLE -> EXEC -> DONE -> IDLE.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is
// high only in IDLE, inputs offered while it is low are ignored (no queueing), and all command
// fields are captured at the transfer so EXEC never looks at the live inputs.
// Ports:
//   clka       clock                    rst        synchronous active-high reset
//   cmd_valid  command offered          cmd_ready  command accepted when high (IDLE)
//   cmd_op     CLEAR/LOAD/COMPARE/WRITE row_sel    LOAD target row and doutb row
//   addr       word address             dina       write data
//   key        compare key              mask       bit mask, 1 = participates
//   done       one-cycle completion     tags       registered per-row match flags
//   any_match  |tags                    match_cnt  popcount of tags (optional)
//   doutb      async read of mem[row_sel][addr] from live inputs
//   state_dbg  current FSM state, for debug/checkers
// Optional feature: define CAM_MATCH_CNT_EN to build the registered match_cnt popcount;
// otherwise match_cnt is tied to 0.
module cam_array
  import ap_cam_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 1,
  parameter int ROWS          = 16,
  parameter int ROW_BITS      = $clog2(ROWS),
  parameter int CNT_W         = $clog2(ROWS + 1)
) (
  input  logic                     clka,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ROW_BITS-1:0]      row_sel,
  input  logic [RAM_ADDR_BITS-1:0] addr,
  input  logic [RAM_WIDTH-1:0]     dina,
  input  logic [RAM_WIDTH-1:0]     key,
  input  logic [RAM_WIDTH-1:0]     mask,
  output logic                     done,
  output logic [ROWS-1:0]          tags,
  output logic                     any_match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [RAM_WIDTH-1:0]     doutb,
  output logic [1:0]               state_dbg
);

  cam_state_e state_q, state_d;

  cam_op_e                  op_q;
  logic [ROW_BITS-1:0]      row_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_WIDTH-1:0]     dina_q, key_q, mask_q;

  logic [RAM_ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic [ROWS-1:0]          tags_q, tags_d;
  logic [ROWS-1:0]          match_vec;
  logic [RAM_WIDTH-1:0]     rd_data [ROWS];

  logic accept, exec, clr_last;
  logic [RAM_ADDR_BITS-1:0] row_waddr;
  logic [RAM_WIDTH-1:0]     row_wdata, row_wmask;

  assign accept   = cmd_valid && (state_q == ST_IDLE);
  assign exec     = (state_q == ST_EXEC);
  assign clr_last = (clr_cnt_q == '1);

  // ---------------- FSM ----------------
  always_ff @(posedge clka) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_EXEC;
      end
      // CLEAR sweeps one word per cycle; every other op finishes in one EXEC cycle
      ST_EXEC: if (op_q != OP_CLEAR || clr_last) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_dbg = state_q;

  // ---------------- command registers ----------------
  always_ff @(posedge clka) begin
    if (rst) begin
      op_q   <= OP_CLEAR;
      row_q  <= '0;
      addr_q <= '0;
      dina_q <= '0;
      key_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      op_q   <= cam_op_e'(cmd_op);
      row_q  <= row_sel;
      addr_q <= addr;
      dina_q <= dina;
      key_q  <= key;
      mask_q <= mask;
    end
  end

  // ---------------- clear counter and tags ----------------
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    tags_d    = tags_q;
    if (exec) begin
      case (op_q)
        OP_COMPARE: tags_d = match_vec;
        OP_CLEAR: begin
          clr_cnt_d = clr_cnt_q + 1'b1;  // wraps to 0 after the last word
          if (clr_last) tags_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      clr_cnt_q <= '0;
      tags_q    <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
      tags_q    <= tags_d;
    end
  end

  assign tags      = tags_q;
  assign any_match = |tags_q;

`ifdef CAM_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counted from tags_d so the count lands on the same edge as the tags it describes
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      cnt_d = cnt_d + CNT_W'(tags_d[i]);
    end
  end

  always_ff @(posedge clka) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  // ---------------- row array ----------------
  // CLEAR writes zeros through a full mask at the sweep address
  assign row_waddr = (op_q == OP_CLEAR) ? clr_cnt_q : addr_q;
  assign row_wdata = (op_q == OP_CLEAR) ? '0 : dina_q;
  assign row_wmask = (op_q == OP_CLEAR) ? '1 : mask_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic we;

    // rst blocks the write on its edge so an aborted CLEAR leaves word c intact
    always_comb begin
      we = 1'b0;
      if (exec && !rst) begin
        case (op_q)
          OP_CLEAR: we = 1'b1;
          OP_LOAD:  we = (row_q == ROW_BITS'(r));
          OP_WRITE: we = tags_q[r];
          default:  we = 1'b0;
        endcase
      end
    end

    cam_row #(
      .RAM_WIDTH    (RAM_WIDTH),
      .RAM_ADDR_BITS(RAM_ADDR_BITS)
    ) u_row (
      .clk_i     (clka),
      .we_i      (we),
      .wr_addr_i (row_waddr),
      .wr_data_i (row_wdata),
      .wr_mask_i (row_wmask),
      .cmp_addr_i(addr_q),
      .key_i     (key_q),
      .cmp_mask_i(mask_q),
      .match_o   (match_vec[r]),
      .rd_addr_i (addr),
      .rd_data_o (rd_data[r])
    );
  end

  assign doutb = rd_data[row_sel];

endmodule
